// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg: shared widths, reset PC and fetch-queue entry type for the front end.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue: synchronous FIFO of fetch entries; flush wins over push.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + 1'b1;
      end
      if (do_pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[head_q];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit: fetch PC, one-cycle imem request tracking and decode-side queue.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import mips_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pcplus4
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic [CW:0]  occupancy;
  logic         has_room;
  logic         push, pop, empty;
  logic [31:0]  target;
  fetch_entry_t head, push_entry;

  assign target    = word_align(redirect_pc);
  // Reserve a slot for every outstanding request so a response always fits.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign has_room  = (occupancy < (CW+1)'(QDEPTH));

  always_comb begin
    imem_req      = 1'b0;
    imem_addr     = fetch_pc_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (reset) begin
      imem_addr  = RESET_PC;
      fetch_pc_d = RESET_PC;
    end else if (redirect) begin
      imem_req      = 1'b1;
      imem_addr     = target;
      fetch_pc_d    = target + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = target;
    end else if (has_room) begin
      imem_req      = 1'b1;
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // A response landing in a redirect cycle belongs to the abandoned path.
  assign push             = inflight_q && !redirect;
  assign pop              = !empty && out_ready;
  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = inflight_pc_q;

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  assign out_valid   = !empty;
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign out_pcplus4 = empty ? 32'd0 : head.pc + 32'd4;

endmodule

`default_nettype wire
